// File: rtl/par_vec_packer_pkg.sv
// Shared constants and sizing helpers for the partitioned vector packer.
package par_pkg;

   // Number of partitions (lanes) packed into one output vector.
   localparam int NPAR = 2;

   // Partition index constants; element i of the output vector belongs to lane i.
   localparam int PAR0 = 0;
   localparam int PAR1 = 1;

   // Pointer width for a lane FIFO of the given depth (at least one bit).
   function automatic int ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // Count width able to hold the values 0..depth inclusive.
   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/par_lane_fifo.sv
// Single-partition FIFO. Every register here is written only from this lane's
// own push/flush/data and the shared pop strobe, so lane data never mixes.
module par_lane_fifo
   import par_pkg::*;
#(
   parameter int W     = 1,
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_push,
   input  logic [W-1:0] i_data,
   input  logic         i_flush,
   input  logic         i_pop,
   output logic         o_ready,
   output logic         o_nonempty,
   output logic [W-1:0] o_head
);

   localparam int PTR_W = ptr_w(DEPTH);
   localparam int CNT_W = cnt_w(DEPTH);

   logic [W-1:0]     r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;

   logic w_push;
   logic w_pop;

   // Ready comes from the registered count only; a full lane refuses a push
   // even when a pop fires in the same cycle. Flush wins over push.
   assign o_ready    = (r_count < CNT_W'(DEPTH));
   assign o_nonempty = (r_count != '0);
   assign w_push     = i_push && o_ready && !i_flush;
   assign w_pop      = i_pop && o_nonempty;
   assign o_head     = r_mem[r_rd_ptr];

   // Pointer and occupancy update; flush returns the lane to its reset state.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
         else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
      end
   end

   // Element storage, written on an accepted push.
   // NOTE: the array has no reset; its contents are unobservable until a push
   // fills an entry, because the top gates the output on both lanes non-empty.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_data;
   end

endmodule

// File: rtl/par_vec_packer.sv
// Two-lane vector packer: each partition streams into its own FIFO, and a
// vector is offered when both lanes hold data. Element i comes from lane i;
// only the out_valid AND combines the lanes.
module par_vec_packer
   import par_pkg::*;
#(
   parameter int W     = 1,
   parameter int DEPTH = 2
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in0_valid,
   input  logic [W-1:0]   in0_data,
   output logic           in0_ready,
   input  logic           in0_flush,
   input  logic           in1_valid,
   input  logic [W-1:0]   in1_data,
   output logic           in1_ready,
   input  logic           in1_flush,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*W-1:0] out_vec
);

   logic [NPAR-1:0] w_in_valid;
   logic [NPAR-1:0] w_in_flush;
   logic [NPAR-1:0] w_ready;
   logic [NPAR-1:0] w_nonempty;
   logic [W-1:0]    w_in_data [NPAR];
   logic [W-1:0]    w_head    [NPAR];
   logic            w_out_valid;
   logic            w_pop;
   logic [2*W-1:0]  w_vec;

   assign w_in_valid[PAR0] = in0_valid;
   assign w_in_valid[PAR1] = in1_valid;
   assign w_in_flush[PAR0] = in0_flush;
   assign w_in_flush[PAR1] = in1_flush;
   assign w_in_data[PAR0]  = in0_data;
   assign w_in_data[PAR1]  = in1_data;

   // The only cross-lane join: a vector exists when every lane has a head.
   assign w_out_valid = &w_nonempty;
   assign w_pop       = w_out_valid && out_ready;

   // One FIFO per partition; the pop strobe fans out to both lanes at once.
   for (genvar gi = 0; gi < NPAR; gi++) begin : g_lane
      par_lane_fifo #(
         .W     (W),
         .DEPTH (DEPTH)
      ) u_lane (
         .clk        (clk),
         .rst_n      (rst_n),
         .i_push     (w_in_valid[gi]),
         .i_data     (w_in_data[gi]),
         .i_flush    (w_in_flush[gi]),
         .i_pop      (w_pop),
         .o_ready    (w_ready[gi]),
         .o_nonempty (w_nonempty[gi]),
         .o_head     (w_head[gi])
      );
   end

   // Pack lane heads into the vector, driving zero whenever no vector is valid.
   // NOTE: the default assignment first keeps this purely combinational (no latch).
   always_comb begin
      w_vec = '0;
      if (w_out_valid) begin
         for (int i = 0; i < NPAR; i++) w_vec[i*W +: W] = w_head[i];
      end
   end

   assign in0_ready = w_ready[PAR0];
   assign in1_ready = w_ready[PAR1];
   assign out_valid = w_out_valid;
   assign out_vec   = w_vec;

endmodule

// File: tb/tb_par_vec_packer.sv
// Directed bench for par_vec_packer: the driver pushes hand-computed expected
// vectors into a queue, and a monitor checks each accepted vector against it.
module tb_par_vec_packer;

   localparam int W     = 1;
   localparam int DEPTH = 2;

   logic           clk;
   logic           rst_n;
   logic           in0_valid, in1_valid;
   logic [W-1:0]   in0_data, in1_data;
   logic           in0_ready, in1_ready;
   logic           in0_flush, in1_flush;
   logic           out_valid;
   logic           out_ready;
   logic [2*W-1:0] out_vec;

   logic [2*W-1:0] exp_q [$];
   int             n_checks = 0;
   int             n_pass   = 0;
   logic           toggle_rdy = 1'b0;

   par_vec_packer #(.W(W), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in0_valid (in0_valid),
      .in0_data  (in0_data),
      .in0_ready (in0_ready),
      .in0_flush (in0_flush),
      .in1_valid (in1_valid),
      .in1_data  (in1_data),
      .in1_ready (in1_ready),
      .in1_flush (in1_flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_vec   (out_vec)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // Advance to just after the next rising edge; optionally toggle out_ready.
   task automatic tick();
      @(posedge clk);
      #1;
      if (toggle_rdy) out_ready = ~out_ready;
   endtask

   // Wait for the scoreboard to empty, bounded by a cycle budget.
   task automatic wait_drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 40) begin
         tick();
         n++;
      end
      check(name, exp_q.size(), 0);
   endtask

   // Monitor: mid-cycle, compare each vector about to be accepted, and confirm
   // that out_vec is zero whenever no vector is offered.
   always @(negedge clk) begin
      if (rst_n) begin
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("sb_underflow", 0, 1);
            else check("sb_vec", out_vec, exp_q.pop_front());
         end else if (!out_valid) begin
            check("idle_vec_zero", out_vec, 0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      in0_valid = 1'b0; in0_data = '0; in0_flush = 1'b0;
      in1_valid = 1'b0; in1_data = '0; in1_flush = 1'b0;
      out_ready = 1'b0;
      #22 rst_n = 1'b1;

      // Reset then idle
      for (int i = 0; i < 5; i++) begin
         tick();
         check("rst_in0_ready", in0_ready, 1);
         check("rst_in1_ready", in1_ready, 1);
         check("rst_out_valid", out_valid, 0);
         check("rst_out_vec", out_vec, 0);
      end

      // Pair and drain
      in0_valid = 1'b1; in0_data = 1'b1;
      tick();
      in0_valid = 1'b0;
      check("pair_one_lane_valid", out_valid, 0);
      in1_valid = 1'b1; in1_data = 1'b0;
      exp_q.push_back(2'b01);
      tick();
      in1_valid = 1'b0;
      check("pair_valid", out_valid, 1);
      check("pair_vec", out_vec, 2'b01);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("pair_drained", out_valid, 0);

      // Full lane: third push rejected
      in0_valid = 1'b1; in0_data = 1'b1;
      tick();
      check("full_ready_after1", in0_ready, 1);
      in0_data = 1'b0;
      tick();
      check("full_ready_after2", in0_ready, 0);
      in0_data = 1'b1;
      tick();
      in0_valid = 1'b0;
      check("full_ready_after3", in0_ready, 0);
      check("full_no_vec", out_valid, 0);
      in1_valid = 1'b1; in1_data = 1'b1;
      tick();
      in1_valid = 1'b0;
      check("full_pair_valid", out_valid, 1);
      check("full_pair_vec", out_vec, 2'b11);
      exp_q.push_back(2'b11);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("full_ready_back", in0_ready, 1);
      check("full_after_pop_valid", out_valid, 0);
      in1_valid = 1'b1; in1_data = 1'b0;
      exp_q.push_back(2'b00);
      tick();
      in1_valid = 1'b0;
      check("full_second_valid", out_valid, 1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("full_lane0_empty", out_valid, 0);
      // A third lane0 element would pair with this one if it had been accepted.
      in1_valid = 1'b1; in1_data = 1'b1;
      tick();
      in1_valid = 1'b0;
      check("full_third_rejected", out_valid, 0);
      in1_flush = 1'b1;
      tick();
      in1_flush = 1'b0;
      check("full_cleanup_ready1", in1_ready, 1);

      // Wrap-around with out_ready toggling
      toggle_rdy = 1'b1;
      for (int k = 0; k < 8; k++) begin
         int n = 0;
         logic b;
         b = k[0];
         while (!(in0_ready && in1_ready) && n < 20) begin
            tick();
            n++;
         end
         check("wrap_ready_wait", n < 20, 1);
         in0_valid = 1'b1; in0_data = b;
         in1_valid = 1'b1; in1_data = ~b;
         exp_q.push_back({~b, b});
         tick();
         in0_valid = 1'b0; in1_valid = 1'b0;
      end
      toggle_rdy = 1'b0;
      out_ready  = 1'b1;
      wait_drain("wrap_drain");
      out_ready = 1'b0;
      check("wrap_empty_valid", out_valid, 0);

      // Flush lane1 with a same-cycle push
      in0_valid = 1'b1; in0_data = 1'b1;
      in1_valid = 1'b1; in1_data = 1'b0;
      tick();
      in0_data = 1'b0;
      in1_data = 1'b1;
      tick();
      in0_valid = 1'b0; in1_valid = 1'b0;
      check("flush_pre_vec", out_vec, 2'b01);
      check("flush_pre_ready0", in0_ready, 0);
      in1_flush = 1'b1; in1_valid = 1'b1; in1_data = 1'b1;
      tick();
      in1_flush = 1'b0; in1_valid = 1'b0;
      check("flush_valid", out_valid, 0);
      check("flush_vec", out_vec, 0);
      check("flush_ready1", in1_ready, 1);
      check("flush_lane0_full", in0_ready, 0);
      exp_q.push_back(2'b11);
      exp_q.push_back(2'b00);
      in1_valid = 1'b1; in1_data = 1'b1;
      tick();
      in1_data = 1'b0;
      tick();
      in1_valid = 1'b0;
      out_ready = 1'b1;
      wait_drain("flush_drain");
      out_ready = 1'b0;
      check("flush_end_valid", out_valid, 0);

      // Async reset mid-stream
      in0_valid = 1'b1; in0_data = 1'b1;
      in1_valid = 1'b1; in1_data = 1'b1;
      tick();
      in0_valid = 1'b0; in1_valid = 1'b0;
      check("arst_pre_valid", out_valid, 1);
      #3 rst_n = 1'b0;
      #1;
      check("arst_valid", out_valid, 0);
      check("arst_vec", out_vec, 0);
      check("arst_ready0", in0_ready, 1);
      check("arst_ready1", in1_ready, 1);
      #2 rst_n = 1'b1;
      tick();
      in0_valid = 1'b1; in0_data = 1'b0;
      in1_valid = 1'b1; in1_data = 1'b1;
      exp_q.push_back(2'b10);
      tick();
      in0_valid = 1'b0; in1_valid = 1'b0;
      out_ready = 1'b1;
      wait_drain("arst_recover_drain");
      out_ready = 1'b0;
      check("arst_recover_idle", out_valid, 0);

      tick();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
